input_matrix_server: RTL and testbench
======================================

INPUT_MATRIX_SERVER -- requirements
Module: input_matrix_server

Interface
REQ-001 The block SHALL use: reset reset, synchronous, active-low; clock clk.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning matrix element width.
REQ-003 The block SHALL have parameter ADDR_W, default 10, meaning read/write address width.
REQ-004 The block SHALL have parameter LOAD_LEN, default 1024, meaning number of elements per matrix load, range 1..2**ADDR_W.
REQ-005 The block SHALL have ports:
  clk  in  1  clock
  reset  in  1  sync active-low reset
  host_wr_valid  in  1  host element write request
  host_wr_ready  out  1  server accepts element
  host_wr_data  in  DATA_W  element value
  host_clear  in  1  discard loaded matrix
  host_go  in  1  request computation
  loaded  out  1  full matrix present
  START  out  1  one-cycle launch pulse to accelerator controller
  BUSY  in  1  accelerator busy status
  DONE  in  1  accelerator completion pulse
  input_matrix_ram_en  in  1  controller read enable
  input_matrix_ram_read_en  in  1  controller read qualifier
  input_matrix_ram_address  in  ADDR_W  controller read address
  rd_data  out  DATA_W  read data
  rd_valid  out  1  rd_data valid strobe
  err_rd  out  1  sticky illegal-read flag

Function
REQ-006 The state machine SHALL have states EMPTY, FILL, LOADED, RUN.
REQ-007 host_wr_ready SHALL be 1 in EMPTY and FILL, and 0 in LOADED and RUN.
REQ-008 A write SHALL be accepted when host_wr_valid and host_wr_ready are both 1; the element SHALL be stored at wr_ptr, and wr_ptr SHALL increment by 1.
REQ-009 The first accepted write SHALL move EMPTY to FILL; the accepted write with wr_ptr == LOAD_LEN-1 SHALL move to LOADED (with LOAD_LEN=1, EMPTY SHALL go directly to LOADED).
REQ-010 loaded SHALL be 1 in LOADED and RUN, and 0 otherwise.
REQ-011 In LOADED, host_go SHALL drive START=1 for exactly one cycle (the cycle after host_go is sampled) and move to RUN.
REQ-012 In RUN, a DONE pulse SHALL move to LOADED with memory contents retained, so the same matrix can be rerun by another host_go.
REQ-013 DONE outside RUN SHALL be ignored; host_go outside LOADED SHALL be ignored.
REQ-014 host_clear in EMPTY, FILL or LOADED SHALL move to EMPTY and set wr_ptr=0; host_clear in RUN SHALL be ignored.
REQ-015 If host_clear and an accepted write occur in the same cycle, host_clear SHALL win and the write SHALL be discarded.
REQ-016 A read request (input_matrix_ram_en && input_matrix_ram_read_en) at cycle N SHALL produce rd_valid=1 and rd_data at cycle N+1: fixed 1-cycle latency, one read per cycle, back-to-back reads supported.
REQ-017 A read SHALL be legal only in LOADED or RUN with address < LOAD_LEN; a legal read SHALL return the stored element.
REQ-018 An illegal read SHALL return rd_data=0 with rd_valid=1 and SHALL set err_rd; err_rd SHALL clear only on reset or host_clear.
REQ-019 A read request with only one of the two enables asserted SHALL be ignored: no rd_valid and no error.
REQ-020 BUSY SHALL not be required for any transition; if BUSY=0 for 2 consecutive cycles in RUN after START, err_rd SHALL be set (launch not acknowledged) and the state SHALL remain RUN.
REQ-021 wr_ptr SHALL be ADDR_W+1 bits wide so it cannot wrap before reaching LOAD_LEN.

Reset
REQ-022 On reset=0 at a clk edge: state=EMPTY, wr_ptr=0, START=0, rd_valid=0, rd_data=0, err_rd=0, loaded=0, host_wr_ready=0 during the reset cycle and 1 afterwards.
REQ-023 Reset SHALL not need to clear memory contents; after reset, no reads SHALL be legal until a full reload.
REQ-024 Reset asserted mid-FILL or mid-RUN SHALL abandon the operation with no START or rd_valid emitted in the following cycle.

Structure
REQ-025 A shared package SHALL hold DATA_W, ADDR_W and LOAD_LEN defaults and the server state encoding (EMPTY=0, FILL=1, LOADED=2, RUN=3).
REQ-026 Storage SHALL be one sub-module, input_matrix_mem: simple dual-port, 1 synchronous write port and 1 synchronous read port, 1-cycle read latency, no reset.

Verification
REQ-027 Fill 1024 elements with value i at index i, with host_wr_valid toggling randomly -> loaded=1 exactly after the 1024th accept; host_wr_ready=0 thereafter.
REQ-028 In LOADED, pulse host_go -> START=1 for one cycle; then back-to-back reads of addresses 0,5,1023 -> rd_data 0,5,1023 on consecutive cycles, each 1 cycle after its request.
REQ-029 Read address 3 while in FILL -> rd_valid=1, rd_data=0, err_rd=1; err_rd stays 1 until host_clear.
REQ-030 With LOAD_LEN=16, read address 20 in RUN -> rd_data=0 and err_rd=1; then DONE -> LOADED; host_go -> second START pulse and data unchanged.
REQ-031 host_clear coincident with the 10th accepted write -> state EMPTY, wr_ptr=0; 1024 further writes are needed to reach loaded=1.
REQ-032 Assert reset mid-RUN while a read is requested -> next cycle rd_valid=0, START=0, state EMPTY.

Source files
------------

// File: rtl/input_matrix_server_pkg.sv
// Shared definitions for the input matrix server: default geometry and the
// server state encoding used by the top level and the bench.
package input_matrix_server_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 10;
   localparam int LOAD_LEN_DEF = 1024;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FILL   = 2'd1,
      LOADED = 2'd2,
      RUN    = 2'd3
   } srv_state_t;

   // A complete matrix is resident (and readable) only in LOADED and RUN.
   function automatic logic holds_matrix(input srv_state_t s);
      return (s == LOADED) || (s == RUN);
   endfunction

endpackage

// File: rtl/input_matrix_server_mem.sv
// Element store for the input matrix server: simple dual-port RAM with one
// synchronous write port, one synchronous read port, 1-cycle read latency.
// Contents are deliberately not reset; legality of a read is tracked outside.
module input_matrix_mem
   import input_matrix_server_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_array [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Write port: store one element per cycle when enabled.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_array[wr_addr] <= wr_data;
      end
   end

   // Read port: registered output gives the fixed 1-cycle latency.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data_q <= mem_array[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/input_matrix_server.sv
// Input matrix server: the host streams a full matrix in, then launches the
// accelerator with a one-cycle START; the accelerator reads elements back
// through a 1-cycle-latency port. Out-of-range or premature reads return 0
// and raise a sticky error, as does a launch that BUSY never acknowledges.
module input_matrix_server
   import input_matrix_server_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LOAD_LEN = LOAD_LEN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic              host_clear,
   input  logic              host_go,
   output logic              loaded,
   output logic              START,
   input  logic              BUSY,
   input  logic              DONE,
   input  logic              input_matrix_ram_en,
   input  logic              input_matrix_ram_read_en,
   input  logic [ADDR_W-1:0] input_matrix_ram_address,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              err_rd
);

   // Pointer is one bit wider than the address so it can hold LOAD_LEN itself.
   localparam int              PW       = ADDR_W + 1;
   localparam logic [PW-1:0]   LAST_PTR = PW'(LOAD_LEN - 1);
   localparam logic [PW-1:0]   LEN_P    = PW'(LOAD_LEN);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

   srv_state_t        state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic              start_q, start_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_legal_q, rd_legal_d;
   logic              err_q, err_d;
   logic              ack_q, ack_d;          // BUSY seen since the last launch
   logic              busy_lo_q, busy_lo_d;  // one unacknowledged cycle already seen

   logic              wr_accept;
   logic              mem_we;
   logic              rd_req;
   logic [DATA_W-1:0] mem_rd_data;

   // Ready is withheld while reset is asserted so nothing is accepted then.
   assign host_wr_ready = reset && ((state_q == EMPTY) || (state_q == FILL));
   assign wr_accept     = host_wr_valid && host_wr_ready;
   // A clear in the same cycle discards the write.
   assign mem_we        = wr_accept && !host_clear;
   assign rd_req        = input_matrix_ram_en && input_matrix_ram_read_en;

   // Next-state logic: load sequencing, launch/completion, read legality, errors.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      start_d    = 1'b0;
      err_d      = err_q;
      ack_d      = ack_q;
      busy_lo_d  = busy_lo_q;
      rd_valid_d = rd_req;
      rd_legal_d = rd_req && holds_matrix(state_q) &&
                   ({1'b0, input_matrix_ram_address} < LEN_P);

      case (state_q)
         EMPTY, FILL: begin
            if (host_clear) begin
               state_d  = EMPTY;
               wr_ptr_d = '0;
               err_d    = 1'b0;
            end else if (wr_accept) begin
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               state_d  = (wr_ptr_q == LAST_PTR) ? LOADED : FILL;
            end
         end
         LOADED: begin
            if (host_clear) begin
               state_d  = EMPTY;
               wr_ptr_d = '0;
               err_d    = 1'b0;
            end else if (host_go) begin
               state_d   = RUN;
               start_d   = 1'b1;
               ack_d     = 1'b0;
               busy_lo_d = 1'b0;
            end
         end
         RUN: begin
            if (DONE) begin
               state_d = LOADED;
            end else if (!start_q && !ack_q) begin
               // Watch the cycles after START for the accelerator to raise BUSY.
               if (BUSY) begin
                  ack_d = 1'b1;
               end else if (busy_lo_q) begin
                  err_d = 1'b1;
                  ack_d = 1'b1;
               end else begin
                  busy_lo_d = 1'b1;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      // An illegal read is recorded even if a clear lands in the same cycle.
      if (rd_req && !rd_legal_d) begin
         err_d = 1'b1;
      end
   end

   // State and registered outputs; reset abandons any fill or run in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= EMPTY;
         wr_ptr_q   <= '0;
         start_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_legal_q <= 1'b0;
         err_q      <= 1'b0;
         ack_q      <= 1'b0;
         busy_lo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         start_q    <= start_d;
         rd_valid_q <= rd_valid_d;
         rd_legal_q <= rd_legal_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
         busy_lo_q  <= busy_lo_d;
      end
   end

   input_matrix_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data (host_wr_data),
      .rd_en   (rd_req),
      .rd_addr (input_matrix_ram_address),
      .rd_data (mem_rd_data)
   );

   // Illegal reads (and the reset state) present zero instead of stale RAM data.
   assign rd_data  = rd_legal_q ? mem_rd_data : '0;
   assign rd_valid = rd_valid_q;
   assign START    = start_q;
   assign loaded   = holds_matrix(state_q);
   assign err_rd   = err_q;

endmodule

// File: tb/tb_input_matrix_server.sv
// Directed bench for input_matrix_server: a default-size instance (1024
// elements) and a small instance (LOAD_LEN=16) for range checks.
module tb_input_matrix_server;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Default instance
   logic        reset, host_wr_valid, host_wr_ready, host_clear, host_go;
   logic [15:0] host_wr_data, rd_data;
   logic        loaded, START, BUSY, DONE, ram_en, ram_read_en, rd_valid, err_rd;
   logic [9:0]  ram_addr;

   // LOAD_LEN=16 instance
   logic        s_reset, s_valid, s_ready, s_clear, s_go;
   logic [15:0] s_wdata, s_rdata;
   logic        s_loaded, s_START, s_BUSY, s_DONE, s_en, s_rd_en, s_rvalid, s_err;
   logic [9:0]  s_addr;

   input_matrix_server u_dut (
      .clk                      (clk),
      .reset                    (reset),
      .host_wr_valid            (host_wr_valid),
      .host_wr_ready            (host_wr_ready),
      .host_wr_data             (host_wr_data),
      .host_clear               (host_clear),
      .host_go                  (host_go),
      .loaded                   (loaded),
      .START                    (START),
      .BUSY                     (BUSY),
      .DONE                     (DONE),
      .input_matrix_ram_en      (ram_en),
      .input_matrix_ram_read_en (ram_read_en),
      .input_matrix_ram_address (ram_addr),
      .rd_data                  (rd_data),
      .rd_valid                 (rd_valid),
      .err_rd                   (err_rd)
   );

   input_matrix_server #(.DATA_W(16), .ADDR_W(10), .LOAD_LEN(16)) u_dut16 (
      .clk                      (clk),
      .reset                    (s_reset),
      .host_wr_valid            (s_valid),
      .host_wr_ready            (s_ready),
      .host_wr_data             (s_wdata),
      .host_clear               (s_clear),
      .host_go                  (s_go),
      .loaded                   (s_loaded),
      .START                    (s_START),
      .BUSY                     (s_BUSY),
      .DONE                     (s_DONE),
      .input_matrix_ram_en      (s_en),
      .input_matrix_ram_read_en (s_rd_en),
      .input_matrix_ram_address (s_addr),
      .rd_data                  (s_rdata),
      .rd_valid                 (s_rvalid),
      .err_rd                   (s_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Continuous writes of base+i; only used where ready is known to be high.
   task automatic write_n(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         host_wr_valid = 1'b1;
         host_wr_data  = base + 16'(i);
         tick();
      end
      host_wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", host_wr_ready); end
      total++; if (loaded !== 1'b0) begin bad++; $display("FAIL reset_loaded got=%0b want=0", loaded); end
      total++; if (START !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", START); end
      total++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin bad++; $display("FAIL reset_rd got=%0b/%h want=0/0000", rd_valid, rd_data); end
      total++; if (err_rd !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err_rd); end
      total++; if (u_dut.state_q !== 2'd0 || u_dut.wr_ptr_q !== 11'd0) begin bad++; $display("FAIL reset_state got=%0d/%0d want=0/0", u_dut.state_q, u_dut.wr_ptr_q); end
      reset = 1'b1;
      #1;
      total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b want=1", host_wr_ready); end
      $display("reset: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_read_in_fill();
      write_n(4, 16'hA000);
      total++; if (u_dut.state_q !== 2'd1 || u_dut.wr_ptr_q !== 11'd4) begin bad++; $display("FAIL fill_state got=%0d/%0d want=1/4", u_dut.state_q, u_dut.wr_ptr_q); end
      ram_en = 1'b1; ram_read_en = 1'b1; ram_addr = 10'd3;
      tick();
      ram_en = 1'b0; ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'h0) begin bad++; $display("FAIL fill_read got=%0b/%h want=1/0000", rd_valid, rd_data); end
      total++; if (err_rd !== 1'b1) begin bad++; $display("FAIL fill_read_err got=%0b want=1", err_rd); end
      tick();
      tick();
      total++; if (err_rd !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL err_sticky got=%0b/%0b want=1/0", err_rd, rd_valid); end
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      total++; if (err_rd !== 1'b0 || u_dut.state_q !== 2'd0 || u_dut.wr_ptr_q !== 11'd0) begin bad++; $display("FAIL clear_err got=%0b/%0d/%0d want=0/0/0", err_rd, u_dut.state_q, u_dut.wr_ptr_q); end
      $display("read_in_fill: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_clear_collision();
      write_n(9, 16'h5500);
      total++; if (u_dut.wr_ptr_q !== 11'd9) begin bad++; $display("FAIL coll_ptr9 got=%0d want=9", u_dut.wr_ptr_q); end
      host_wr_valid = 1'b1; host_wr_data = 16'hDEAD; host_clear = 1'b1;
      tick();
      host_wr_valid = 1'b0; host_clear = 1'b0;
      total++; if (u_dut.state_q !== 2'd0 || u_dut.wr_ptr_q !== 11'd0 || loaded !== 1'b0) begin bad++; $display("FAIL coll_clear got=%0d/%0d/%0b want=0/0/0", u_dut.state_q, u_dut.wr_ptr_q, loaded); end
      // Only one enable: ignored entirely.
      ram_en = 1'b0; ram_read_en = 1'b1; ram_addr = 10'd0;
      tick();
      ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b0 || err_rd !== 1'b0) begin bad++; $display("FAIL half_read got=%0b/%0b want=0/0", rd_valid, err_rd); end
      $display("clear_collision: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_fill();
      int   acc = 0;
      int   cyc = 0;
      int   early = 0;
      logic a;
      while (acc < 1024 && cyc < 20000) begin
         host_wr_valid = 1'($urandom_range(0, 1));
         host_wr_data  = 16'(acc);
         a = host_wr_valid && host_wr_ready;
         tick();
         cyc++;
         if (a) acc++;
         if (acc < 1024 && loaded !== 1'b0) early++;
      end
      host_wr_valid = 1'b0;
      total++; if (acc !== 1024) begin bad++; $display("FAIL fill_accepts got=%0d want=1024", acc); end
      total++; if (early !== 0) begin bad++; $display("FAIL fill_early_loaded got=%0d want=0", early); end
      total++; if (loaded !== 1'b1 || host_wr_ready !== 1'b0) begin bad++; $display("FAIL fill_done got=%0b/%0b want=1/0", loaded, host_wr_ready); end
      host_wr_valid = 1'b1; host_wr_data = 16'hFFFF;
      tick();
      host_wr_valid = 1'b0;
      total++; if (u_dut.wr_ptr_q !== 11'd1024 || u_dut.state_q !== 2'd2) begin bad++; $display("FAIL write_when_loaded got=%0d/%0d want=1024/2", u_dut.wr_ptr_q, u_dut.state_q); end
      $display("fill: accepts=%0d cycles=%0d total=%0d bad=%0d", acc, cyc, total, bad);
   endtask

   task automatic test_go_and_reads();
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      BUSY = 1'b1;
      total++; if (START !== 1'b1 || u_dut.state_q !== 2'd3) begin bad++; $display("FAIL go_start got=%0b/%0d want=1/3", START, u_dut.state_q); end
      tick();
      total++; if (START !== 1'b0) begin bad++; $display("FAIL start_width got=%0b want=0", START); end
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      total++; if (START !== 1'b0) begin bad++; $display("FAIL go_in_run got=%0b want=0", START); end
      ram_en = 1'b1; ram_read_en = 1'b1; ram_addr = 10'd0;
      tick();
      ram_addr = 10'd5;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'd0) begin bad++; $display("FAIL rd0 got=%0b/%0d want=1/0", rd_valid, rd_data); end
      tick();
      ram_addr = 10'd1023;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'd5) begin bad++; $display("FAIL rd5 got=%0b/%0d want=1/5", rd_valid, rd_data); end
      tick();
      ram_en = 1'b0; ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'd1023) begin bad++; $display("FAIL rd1023 got=%0b/%0d want=1/1023", rd_valid, rd_data); end
      tick();
      total++; if (rd_valid !== 1'b0 || err_rd !== 1'b0) begin bad++; $display("FAIL rd_idle got=%0b/%0b want=0/0", rd_valid, err_rd); end
      $display("go_and_reads: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_done_rerun();
      host_clear = 1'b1;
      tick();
      host_clear = 1'b0;
      total++; if (u_dut.state_q !== 2'd3) begin bad++; $display("FAIL clear_in_run got=%0d want=3", u_dut.state_q); end
      DONE = 1'b1;
      tick();
      DONE = 1'b0; BUSY = 1'b0;
      total++; if (u_dut.state_q !== 2'd2 || loaded !== 1'b1) begin bad++; $display("FAIL done got=%0d/%0b want=2/1", u_dut.state_q, loaded); end
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      total++; if (u_dut.state_q !== 2'd2) begin bad++; $display("FAIL done_in_loaded got=%0d want=2", u_dut.state_q); end
      host_go = 1'b1;
      tick();
      host_go = 1'b0; BUSY = 1'b1;
      total++; if (START !== 1'b1) begin bad++; $display("FAIL rerun_start got=%0b want=1", START); end
      ram_en = 1'b1; ram_read_en = 1'b1; ram_addr = 10'd777;
      tick();
      ram_en = 1'b0; ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'd777) begin bad++; $display("FAIL rerun_rd777 got=%0b/%0d want=1/777", rd_valid, rd_data); end
      $display("done_rerun: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_busy_watchdog();
      DONE = 1'b1;
      tick();
      DONE = 1'b0; BUSY = 1'b0;
      host_go = 1'b1;
      tick();
      host_go = 1'b0;
      tick();
      tick();
      total++; if (err_rd !== 1'b0) begin bad++; $display("FAIL wd_early got=%0b want=0", err_rd); end
      tick();
      total++; if (err_rd !== 1'b1 || u_dut.state_q !== 2'd3) begin bad++; $display("FAIL wd_fire got=%0b/%0d want=1/3", err_rd, u_dut.state_q); end
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      $display("busy_watchdog: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_reset_mid_run();
      host_go = 1'b1;
      tick();
      host_go = 1'b0; BUSY = 1'b1;
      tick();
      reset = 1'b0; ram_en = 1'b1; ram_read_en = 1'b1; ram_addr = 10'd5;
      tick();
      ram_en = 1'b0; ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b0 || START !== 1'b0) begin bad++; $display("FAIL rst_run_out got=%0b/%0b want=0/0", rd_valid, START); end
      total++; if (u_dut.state_q !== 2'd0 || loaded !== 1'b0 || err_rd !== 1'b0) begin bad++; $display("FAIL rst_run_state got=%0d/%0b/%0b want=0/0/0", u_dut.state_q, loaded, err_rd); end
      reset = 1'b1; BUSY = 1'b0;
      ram_en = 1'b1; ram_read_en = 1'b1; ram_addr = 10'd5;
      tick();
      ram_en = 1'b0; ram_read_en = 1'b0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 16'd0 || err_rd !== 1'b1) begin bad++; $display("FAIL rd_after_reset got=%0b/%0d/%0b want=1/0/1", rd_valid, rd_data, err_rd); end
      $display("reset_mid_run: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_load16();
      s_reset = 1'b0;
      tick();
      s_reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_wdata = 16'h0100 + 16'(i);
         tick();
         if (i == 14) begin
            total++; if (s_loaded !== 1'b0) begin bad++; $display("FAIL l16_early got=%0b want=0", s_loaded); end
         end
      end
      s_valid = 1'b0;
      total++; if (s_loaded !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL l16_loaded got=%0b/%0b want=1/0", s_loaded, s_ready); end
      s_go = 1'b1;
      tick();
      s_go = 1'b0; s_BUSY = 1'b1;
      total++; if (s_START !== 1'b1) begin bad++; $display("FAIL l16_start got=%0b want=1", s_START); end
      s_en = 1'b1; s_rd_en = 1'b1; s_addr = 10'd20;
      tick();
      s_addr = 10'd15;
      total++; if (s_rvalid !== 1'b1 || s_rdata !== 16'h0 || s_err !== 1'b1) begin bad++; $display("FAIL l16_rd20 got=%0b/%h/%0b want=1/0000/1", s_rvalid, s_rdata, s_err); end
      tick();
      s_en = 1'b0; s_rd_en = 1'b0;
      total++; if (s_rvalid !== 1'b1 || s_rdata !== 16'h010F) begin bad++; $display("FAIL l16_rd15 got=%0b/%h want=1/010f", s_rvalid, s_rdata); end
      s_DONE = 1'b1;
      tick();
      s_DONE = 1'b0; s_BUSY = 1'b0;
      total++; if (u_dut16.state_q !== 2'd2) begin bad++; $display("FAIL l16_done got=%0d want=2", u_dut16.state_q); end
      s_go = 1'b1;
      tick();
      s_go = 1'b0; s_BUSY = 1'b1;
      total++; if (s_START !== 1'b1) begin bad++; $display("FAIL l16_start2 got=%0b want=1", s_START); end
      s_en = 1'b1; s_rd_en = 1'b1; s_addr = 10'd7;
      tick();
      s_en = 1'b0; s_rd_en = 1'b0;
      total++; if (s_rvalid !== 1'b1 || s_rdata !== 16'h0107 || s_err !== 1'b1) begin bad++; $display("FAIL l16_rd7 got=%0b/%h/%0b want=1/0107/1", s_rvalid, s_rdata, s_err); end
      $display("load16: total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      reset = 1'b0; host_wr_valid = 1'b0; host_wr_data = '0; host_clear = 1'b0; host_go = 1'b0;
      BUSY = 1'b0; DONE = 1'b0; ram_en = 1'b0; ram_read_en = 1'b0; ram_addr = '0;
      s_reset = 1'b0; s_valid = 1'b0; s_wdata = '0; s_clear = 1'b0; s_go = 1'b0;
      s_BUSY = 1'b0; s_DONE = 1'b0; s_en = 1'b0; s_rd_en = 1'b0; s_addr = '0;
      test_reset();
      test_read_in_fill();
      test_clear_collision();
      test_fill();
      test_go_and_reads();
      test_done_rerun();
      test_busy_watchdog();
      test_reset_mid_run();
      test_load16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "simulation time limit reached");
   end

endmodule
